pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and flush controller for the 5-stage IF/ID/EX/MEM/WB datapath. It keeps a shadow copy of each in-flight instruction's register usage for the EX, MEM and WB stages. From that state it drives PC/IF_ID hold, ID_EX bubble insertion, branch flush masks and EX operand forwarding selects. Mode parameters select forwarding versus stall-only operation and the stage in which branches resolve.

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage instruction, branch and hazard-control signals shared between the
// pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 3
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              br_taken;

    logic              pc_hold;
    logic              ifid_hold;
    logic              idex_bubble;
    logic [2:0]        flush_mask;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              ex_valid;
    logic              mem_valid;
    logic              wb_valid;
    logic [15:0]       stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_memread, br_taken,
        input  pc_hold, ifid_hold, idex_bubble, flush_mask, fwd_a, fwd_b,
               ex_valid, mem_valid, wb_valid, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_memread, br_taken,
        output pc_hold, ifid_hold, idex_bubble, flush_mask, fwd_a, fwd_b,
               ex_valid, mem_valid, wb_valid, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush controller for a 5-stage pipeline: tracks EX/MEM/WB register
// usage and drives hold, bubble, flush and EX forwarding selects.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW   = 3,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned BR_STAGE = 3,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } dst_t;

    localparam logic [2:0] FLUSH_BR = (BR_STAGE == 3) ? 3'b111 : 3'b011;

    dst_t              ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic              ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              stall, stall_eff, br;
    logic [2:0]        flush;
    logic [1:0]        fwd_a, fwd_b;

    function automatic logic match(dst_t s, logic [REG_AW-1:0] r, logic used);
        return used && s.valid && s.regwrite && (s.rd == r) && !(ZERO_REG && (r == '0));
    endfunction

    function automatic logic [1:0] fwd_sel(logic [REG_AW-1:0] r, logic used);
        if (match(mem_q, r, used) && !mem_q.memread) return 2'b01;
        if (match(wb_q, r, used))                    return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        if (FWD_EN)
            stall = bus.id_valid && ex_q.memread &&
                    (match(ex_q, bus.id_rs1, bus.id_rs1_used) ||
                     match(ex_q, bus.id_rs2, bus.id_rs2_used));
        else
            stall = bus.id_valid &&
                    (match(ex_q,  bus.id_rs1, bus.id_rs1_used) ||
                     match(ex_q,  bus.id_rs2, bus.id_rs2_used) ||
                     match(mem_q, bus.id_rs1, bus.id_rs1_used) ||
                     match(mem_q, bus.id_rs2, bus.id_rs2_used) ||
                     match(wb_q,  bus.id_rs1, bus.id_rs1_used) ||
                     match(wb_q,  bus.id_rs2, bus.id_rs2_used));

        br        = bus.br_taken && !rst;
        stall_eff = stall && !bus.br_taken && !rst;
        flush     = br ? FLUSH_BR : 3'b000;

        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN && ex_q.valid && !rst) begin
            fwd_a = fwd_sel(ex_rs1_q, ex_rs1_used_q);
            fwd_b = fwd_sel(ex_rs2_q, ex_rs2_used_q);
        end

        wb_d  = mem_q;
        mem_d = flush[2] ? '0 : ex_q;

        // Stalled, flushed or empty ID slots enter EX as an all-zero bubble.
        if (stall_eff || flush[1] || !bus.id_valid) begin
            ex_d          = '0;
            ex_rs1_d      = '0;
            ex_rs2_d      = '0;
            ex_rs1_used_d = 1'b0;
            ex_rs2_used_d = 1'b0;
        end else begin
            ex_d          = '{valid: 1'b1, rd: bus.id_rd,
                              regwrite: bus.id_regwrite, memread: bus.id_memread};
            ex_rs1_d      = bus.id_rs1;
            ex_rs2_d      = bus.id_rs2;
            ex_rs1_used_d = bus.id_rs1_used;
            ex_rs2_used_d = bus.id_rs2_used;
        end

        cnt_d = (stall_eff && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rs1_used_q <= ex_rs1_used_d;
            ex_rs2_used_q <= ex_rs2_used_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.pc_hold     = stall_eff;
    assign bus.ifid_hold   = stall_eff;
    assign bus.idex_bubble = stall_eff;
    assign bus.flush_mask  = flush;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.ex_valid    = ex_q.valid  && !rst;
    assign bus.mem_valid   = mem_q.valid && !rst;
    assign bus.wb_valid    = wb_q.valid  && !rst;
    assign bus.stall_cnt   = rst ? 16'h0000 : cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl: forwarding, stall-only and
// EX-resolved-branch variants driven from one table plus corner sequences.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ins = {valid, rs1[2:0], rs1_used, rs2[2:0], rs2_used, rd[2:0], regwrite, memread}
    typedef struct {
        int          d;
        string       nm;
        logic        r;
        logic        b;
        logic [13:0] ins;
        logic [12:0] exp;
        logic [15:0] cnt;
    } vec_t;

    logic [14:0] in_f = '0, in_n = '0, in_b = '0;
    int n_tests = 0, n_fail = 0;
    vec_t tbl[$];

    pipe_hazard_ctrl_if #(.REG_AW(3)) if_f ();
    pipe_hazard_ctrl_if #(.REG_AW(3)) if_n ();
    pipe_hazard_ctrl_if #(.REG_AW(3)) if_b ();

    assign {if_f.id_valid, if_f.id_rs1, if_f.id_rs1_used, if_f.id_rs2, if_f.id_rs2_used,
            if_f.id_rd, if_f.id_regwrite, if_f.id_memread, if_f.br_taken} = in_f;
    assign {if_n.id_valid, if_n.id_rs1, if_n.id_rs1_used, if_n.id_rs2, if_n.id_rs2_used,
            if_n.id_rd, if_n.id_regwrite, if_n.id_memread, if_n.br_taken} = in_n;
    assign {if_b.id_valid, if_b.id_rs1, if_b.id_rs1_used, if_b.id_rs2, if_b.id_rs2_used,
            if_b.id_rd, if_b.id_regwrite, if_b.id_memread, if_b.br_taken} = in_b;

    pipe_hazard_ctrl #(.REG_AW(3), .FWD_EN(1'b1), .BR_STAGE(3), .ZERO_REG(1'b1))
        u_f (.clk(clk), .rst(rst), .bus(if_f));
    pipe_hazard_ctrl #(.REG_AW(3), .FWD_EN(1'b0), .BR_STAGE(3), .ZERO_REG(1'b1))
        u_n (.clk(clk), .rst(rst), .bus(if_n));
    pipe_hazard_ctrl #(.REG_AW(3), .FWD_EN(1'b1), .BR_STAGE(2), .ZERO_REG(1'b1))
        u_b (.clk(clk), .rst(rst), .bus(if_b));

    localparam logic [13:0] IDLE = 14'd0;

    function automatic logic [13:0] ins(logic [2:0] rs1, logic u1, logic [2:0] rs2, logic u2,
                                        logic [2:0] rd, logic rw, logic mr);
        return {1'b1, rs1, u1, rs2, u2, rd, rw, mr};
    endfunction

    function automatic logic [12:0] E(logic [2:0] ctl, logic [2:0] fl, logic [1:0] fa,
                                      logic [1:0] fb, logic [2:0] v);
        return {ctl, fl, fa, fb, v};
    endfunction

    function automatic vec_t mk(int d, string nm, logic r, logic b, logic [13:0] i,
                                logic [12:0] e, logic [15:0] c);
        vec_t v;
        v.d = d; v.nm = nm; v.r = r; v.b = b; v.ins = i; v.exp = e; v.cnt = c;
        return v;
    endfunction

    function automatic logic [12:0] obs(int d);
        case (d)
            0: return {if_f.pc_hold, if_f.ifid_hold, if_f.idex_bubble, if_f.flush_mask,
                       if_f.fwd_a, if_f.fwd_b, if_f.ex_valid, if_f.mem_valid, if_f.wb_valid};
            1: return {if_n.pc_hold, if_n.ifid_hold, if_n.idex_bubble, if_n.flush_mask,
                       if_n.fwd_a, if_n.fwd_b, if_n.ex_valid, if_n.mem_valid, if_n.wb_valid};
            default: return {if_b.pc_hold, if_b.ifid_hold, if_b.idex_bubble, if_b.flush_mask,
                       if_b.fwd_a, if_b.fwd_b, if_b.ex_valid, if_b.mem_valid, if_b.wb_valid};
        endcase
    endfunction

    function automatic logic [15:0] cntv(int d);
        case (d)
            0:       return if_f.stall_cnt;
            1:       return if_n.stall_cnt;
            default: return if_b.stall_cnt;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(int d, logic r, logic b, logic [13:0] i);
        rst  = r;
        in_f = '0;
        in_n = '0;
        in_b = '0;
        case (d)
            0:       in_f = {i, b};
            1:       in_n = {i, b};
            default: in_b = {i, b};
        endcase
    endtask

    // Check outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc(int d, string nm, logic [12:0] e, logic [15:0] c);
        @(negedge clk);
        chk({nm, "/ctl"}, 32'(obs(d)), 32'(e));
        chk({nm, "/cnt"}, 32'(cntv(d)), 32'(c));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [13:0] cons2, ld2;
        int stalls;
        bit st;
        cons2 = ins(3'd2, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        ld2   = ins(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);

        // Forwarding DUT: reset, load-use, ALU chain, priority, BR_STAGE=3 flush, zero reg
        tbl.push_back(mk(0, "rst0",      1, 1, cons2, E(3'b000,3'b000,2'b00,2'b00,3'b000), 0));
        tbl.push_back(mk(0, "rst1",      1, 1, cons2, E(3'b000,3'b000,2'b00,2'b00,3'b000), 0));
        tbl.push_back(mk(0, "ld",        0, 0, ld2,   E(3'b000,3'b000,2'b00,2'b00,3'b000), 0));
        tbl.push_back(mk(0, "lu_stall",  0, 0, cons2, E(3'b111,3'b000,2'b00,2'b00,3'b100), 0));
        tbl.push_back(mk(0, "lu_go",     0, 0, cons2, E(3'b000,3'b000,2'b00,2'b00,3'b010), 1));
        tbl.push_back(mk(0, "lu_fwd",    0, 0, IDLE,  E(3'b000,3'b000,2'b10,2'b00,3'b101), 1));
        tbl.push_back(mk(0, "w3",        0, 0, ins(3'd0,1'b0,3'd0,1'b0,3'd3,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b010), 1));
        tbl.push_back(mk(0, "c_rs2",     0, 0, ins(3'd0,1'b0,3'd3,1'b1,3'd5,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b101), 1));
        tbl.push_back(mk(0, "c_rs1",     0, 0, ins(3'd3,1'b1,3'd0,1'b0,3'd6,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b01,3'b110), 1));
        tbl.push_back(mk(0, "fwd_wb",    0, 0, IDLE,  E(3'b000,3'b000,2'b10,2'b00,3'b111), 1));
        tbl.push_back(mk(0, "w7a",       0, 0, ins(3'd0,1'b0,3'd0,1'b0,3'd7,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b011), 1));
        tbl.push_back(mk(0, "w7b",       0, 0, ins(3'd0,1'b0,3'd0,1'b0,3'd7,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b101), 1));
        tbl.push_back(mk(0, "c77",       0, 0, ins(3'd7,1'b1,3'd7,1'b1,3'd0,1'b0,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b110), 1));
        tbl.push_back(mk(0, "fwd_prio",  0, 0, IDLE,  E(3'b000,3'b000,2'b01,2'b01,3'b111), 1));
        tbl.push_back(mk(0, "ld2",       0, 0, ld2,   E(3'b000,3'b000,2'b00,2'b00,3'b011), 1));
        tbl.push_back(mk(0, "br3_lu",    0, 1, cons2, E(3'b000,3'b111,2'b00,2'b00,3'b101), 1));
        tbl.push_back(mk(0, "br3_again", 0, 1, IDLE,  E(3'b000,3'b111,2'b00,2'b00,3'b000), 1));
        tbl.push_back(mk(0, "post_br",   0, 0, IDLE,  E(3'b000,3'b000,2'b00,2'b00,3'b000), 1));
        tbl.push_back(mk(0, "w0",        0, 0, ins(3'd0,1'b0,3'd0,1'b0,3'd0,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b000), 1));
        tbl.push_back(mk(0, "c0",        0, 0, ins(3'd0,1'b1,3'd0,1'b0,3'd1,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b100), 1));
        tbl.push_back(mk(0, "fwd_zero",  0, 0, IDLE,  E(3'b000,3'b000,2'b00,2'b00,3'b110), 1));
        // BR_STAGE=2 DUT
        tbl.push_back(mk(2, "b2_rst",    1, 0, IDLE,  E(3'b000,3'b000,2'b00,2'b00,3'b000), 0));
        tbl.push_back(mk(2, "b2_ld",     0, 0, ld2,   E(3'b000,3'b000,2'b00,2'b00,3'b000), 0));
        tbl.push_back(mk(2, "br2_lu",    0, 1, cons2, E(3'b000,3'b011,2'b00,2'b00,3'b100), 0));
        tbl.push_back(mk(2, "br2_after", 0, 0, IDLE,  E(3'b000,3'b000,2'b00,2'b00,3'b010), 0));
        // Stall-only DUT
        tbl.push_back(mk(1, "n_rst",     1, 0, IDLE,  E(3'b000,3'b000,2'b00,2'b00,3'b000), 0));
        tbl.push_back(mk(1, "n_w3",      0, 0, ins(3'd0,1'b0,3'd0,1'b0,3'd3,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b000), 0));
        tbl.push_back(mk(1, "n_st1",     0, 0, ins(3'd0,1'b0,3'd3,1'b1,3'd5,1'b1,1'b0),
                         E(3'b111,3'b000,2'b00,2'b00,3'b100), 0));
        tbl.push_back(mk(1, "n_st2",     0, 0, ins(3'd0,1'b0,3'd3,1'b1,3'd5,1'b1,1'b0),
                         E(3'b111,3'b000,2'b00,2'b00,3'b010), 1));
        tbl.push_back(mk(1, "n_st3",     0, 0, ins(3'd0,1'b0,3'd3,1'b1,3'd5,1'b1,1'b0),
                         E(3'b111,3'b000,2'b00,2'b00,3'b001), 2));
        tbl.push_back(mk(1, "n_go",      0, 0, ins(3'd0,1'b0,3'd3,1'b1,3'd5,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b000), 3));
        tbl.push_back(mk(1, "n_c2",      0, 0, ins(3'd3,1'b1,3'd0,1'b0,3'd6,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b100), 3));
        tbl.push_back(mk(1, "n_idle",    0, 0, IDLE,  E(3'b000,3'b000,2'b00,2'b00,3'b110), 3));
        tbl.push_back(mk(1, "n_w0",      0, 0, ins(3'd0,1'b0,3'd0,1'b0,3'd0,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b011), 3));
        tbl.push_back(mk(1, "n_c0",      0, 0, ins(3'd0,1'b1,3'd0,1'b0,3'd1,1'b1,1'b0),
                         E(3'b000,3'b000,2'b00,2'b00,3'b101), 3));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].d, tbl[i].r, tbl[i].b, tbl[i].ins);
            cyc(tbl[i].d, tbl[i].nm, tbl[i].exp, tbl[i].cnt);
        end

        // Reset arriving mid-stall abandons it; the first cycle after reset never stalls.
        drive(0, 1, 0, IDLE);  cyc(0, "rm_rst",   E(3'b000,3'b000,2'b00,2'b00,3'b000), 0);
        drive(0, 0, 0, ld2);   cyc(0, "rm_ld",    E(3'b000,3'b000,2'b00,2'b00,3'b000), 0);
        drive(0, 0, 0, cons2); cyc(0, "rm_stall", E(3'b111,3'b000,2'b00,2'b00,3'b100), 0);
        drive(0, 1, 1, cons2); cyc(0, "rm_inrst", E(3'b000,3'b000,2'b00,2'b00,3'b000), 0);
        drive(0, 0, 0, cons2); cyc(0, "rm_first", E(3'b000,3'b000,2'b00,2'b00,3'b000), 0);

        // Saturation: every instruction reads and writes r1, giving 3 stalls per 4 cycles.
        drive(1, 1, 0, IDLE);
        cyc(1, "sat_rst", E(3'b000,3'b000,2'b00,2'b00,3'b000), 0);
        stalls = 0;
        for (int k = 0; stalls < 65540; k++) begin
            drive(1, 0, 0, ins(3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0));
            st = (k % 4) != 0;
            @(negedge clk);
            if (k < 12) chk("sat_hold", 32'(if_n.pc_hold), 32'(st));
            if ((k % 8192) == 0)
                chk("sat_cnt", 32'(if_n.stall_cnt), (stalls > 65535) ? 32'hFFFF : 32'(stalls));
            @(posedge clk);
            #1;
            if (st) stalls++;
        end
        @(negedge clk);
        chk("sat_final", 32'(if_n.stall_cnt), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
